// File: rtl/tile_grid_renderer_if.sv
// Video-side bus of the tile grid renderer: pixel position in, colour out.
//
// Handshake: pixelTick is a valid-only qualifier for horizCount/vertCount.
// There is no ready, because the renderer accepts a pixel on every clock.
// pixelValidOut qualifies red/green/blue in the same way, two clocks later.
interface tile_grid_renderer_if;
  logic       pixelTick;
  logic [9:0] horizCount;
  logic [9:0] vertCount;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       pixelValidOut;

  // Timing generator side
  modport master (
    output pixelTick, horizCount, vertCount,
    input  red, green, blue, pixelValidOut
  );

  // Renderer side
  modport slave (
    input  pixelTick, horizCount, vertCount,
    output red, green, blue, pixelValidOut
  );
endinterface

// File: rtl/tile_grid_renderer.sv
// Tile grid renderer. It maps a pixel to a grid cell and resolves layer priority
// across homeworld, player, bullets and the enemy field. Game state is
// snapshotted at each frame start, so the image never tears. The pipeline has
// two register stages.
module tile_grid_renderer #(
  parameter int HPIXELS      = 640,
  parameter int VPIXELS      = 480,
  parameter int BSIZE        = 40,
  parameter int NBULLETS     = 3,
  parameter int ENEMY_ROWS   = 5,
  parameter int ENEMY_COLS   = 6,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  tile_grid_renderer_if.slave                vid,
  input  logic [3:0]                         blockieee,
  input  logic [12*ENEMY_ROWS*ENEMY_COLS-1:0] ddavers,
  input  logic [12*NBULLETS-1:0]             bulletColor,
  input  logic [4*NBULLETS-1:0]              bulletXLoc,
  input  logic [4*NBULLETS-1:0]              bulletYLoc,
  input  logic                               hitPulse
);

  localparam int NENEMY = ENEMY_ROWS * ENEMY_COLS;

  logic frame_start;

  // Shadow copy of the game state that rendering reads
  logic [3:0]            blk_q;
  logic [12*NENEMY-1:0]  dd_q;
  logic [12*NBULLETS-1:0] bcol_q;
  logic [4*NBULLETS-1:0] bx_q;
  logic [4*NBULLETS-1:0] by_q;

  // Player flash counter
  logic [7:0] flash_q, flash_d;

  // Stage 1
  logic [9:0] cell_x_q, cell_x_d;
  logic [9:0] cell_y_q, cell_y_d;
  logic       in_range_q, in_range_d;
  logic       tick1_q;

  // Stage 2
  logic [11:0] colour_q, colour_d;
  logic        tick2_q;

  // Stage-2 helpers
  logic        bullet_hit;
  logic [9:0]  r_idx;
  logic [9:0]  c_idx;

  assign frame_start = vid.pixelTick && (vid.horizCount == 10'd0) && (vid.vertCount == 10'd0);

  // Latch every game-state input at the frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q  <= '0;
      dd_q   <= '0;
      bcol_q <= '0;
      bx_q   <= '0;
      by_q   <= '0;
    end else if (frame_start) begin
      blk_q  <= blockieee;
      dd_q   <= ddavers;
      bcol_q <= bulletColor;
      bx_q   <= bulletXLoc;
      by_q   <= bulletYLoc;
    end
  end

  // A hit reloads the counter, and the reload beats a coincident frame-start decrement
  always_comb begin
    flash_d = flash_q;
    if (hitPulse) begin
      flash_d = 8'(FLASH_FRAMES);
    end else if (frame_start && (flash_q != 8'd0)) begin
      flash_d = flash_q - 8'd1;
    end
  end

  // Flash counter register
  always_ff @(posedge clk) begin
    if (reset) flash_q <= '0;
    else       flash_q <= flash_d;
  end

  // Stage-1 cell decode. Cell indices keep the full 10 bits, so no high pixel aliases.
  always_comb begin
    cell_x_d   = vid.horizCount / 10'(BSIZE);
    cell_y_d   = vid.vertCount / 10'(BSIZE);
    in_range_d = ({1'b0, vid.horizCount} < 11'(HPIXELS)) &&
                 ({1'b0, vid.vertCount}  < 11'(VPIXELS));
  end

  // Stage-1 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_x_q   <= '0;
      cell_y_q   <= '0;
      in_range_q <= 1'b0;
      tick1_q    <= 1'b0;
    end else begin
      cell_x_q   <= cell_x_d;
      cell_y_q   <= cell_y_d;
      in_range_q <= in_range_d;
      tick1_q    <= vid.pixelTick;
    end
  end

  // Stage-2 priority mux. Earlier rules win; bullets are scanned lowest index first.
  always_comb begin
    colour_d   = 12'h000;
    bullet_hit = 1'b0;
    r_idx      = cell_y_q >> 1;
    c_idx      = (cell_x_q >> 1) - 10'd2;
    if (!in_range_q) begin
      colour_d = 12'h000;
    end else if (cell_x_q == 10'd0) begin
      colour_d = 12'h282;
    end else if ((cell_x_q == 10'd1) && (cell_y_q == {6'd0, blk_q})) begin
      colour_d = flash_q[0] ? 12'hF00 : 12'hFFF;
    end else begin
      for (int k = 0; k < NBULLETS; k++) begin
        if (!bullet_hit &&
            (cell_x_q == {6'd0, bx_q[4*k +: 4]}) &&
            (cell_y_q == {6'd0, by_q[4*k +: 4]}) &&
            (bcol_q[12*k +: 12] != 12'h000)) begin
          colour_d   = bcol_q[12*k +: 12];
          bullet_hit = 1'b1;
        end
      end
      // Enemies occupy odd rows and even columns from 4 onward. Cells outside the field stay backdrop.
      if (!bullet_hit && cell_y_q[0] && !cell_x_q[0] && (cell_x_q >= 10'd4)) begin
        for (int rr = 0; rr < ENEMY_ROWS; rr++) begin
          for (int cc = 0; cc < ENEMY_COLS; cc++) begin
            if ((r_idx == 10'(rr)) && (c_idx == 10'(cc))) begin
              colour_d = dd_q[12*(rr*ENEMY_COLS+cc) +: 12];
            end
          end
        end
      end
    end
  end

  // Stage-2 output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      colour_q <= '0;
      tick2_q  <= 1'b0;
    end else begin
      colour_q <= colour_d;
      tick2_q  <= tick1_q;
    end
  end

  assign vid.red           = colour_q[11:8];
  assign vid.green         = colour_q[7:4];
  assign vid.blue          = colour_q[3:0];
  assign vid.pixelValidOut = tick2_q;

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed testbench for tile_grid_renderer. It uses hand-computed colours and
// counts its assertions. The build uses FLASH_FRAMES=3 and default geometry.
module tb_tile_grid_renderer;

  localparam int NB = 3;
  localparam int ER = 5;
  localparam int EC = 6;

  logic                 clk;
  logic                 reset;
  logic [3:0]           blockieee;
  logic [12*ER*EC-1:0]  ddavers;
  logic [12*NB-1:0]     bulletColor;
  logic [4*NB-1:0]      bulletXLoc;
  logic [4*NB-1:0]      bulletYLoc;
  logic                 hitPulse;

  int n_assert;
  int n_fail;

  tile_grid_renderer_if vid ();

  tile_grid_renderer #(
    .HPIXELS(640), .VPIXELS(480), .BSIZE(40), .NBULLETS(NB),
    .ENEMY_ROWS(ER), .ENEMY_COLS(EC), .FLASH_FRAMES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vid(vid),
    .blockieee(blockieee),
    .ddavers(ddavers),
    .bulletColor(bulletColor),
    .bulletXLoc(bulletXLoc),
    .bulletYLoc(bulletYLoc),
    .hitPulse(hitPulse)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vid.pixelTick  = 1'b0;
    vid.horizCount = 10'h3FF;
    vid.vertCount  = 10'h3FF;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic frame_start(input logic hit);
    vid.pixelTick  = 1'b1;
    vid.horizCount = 10'd0;
    vid.vertCount  = 10'd0;
    hitPulse       = hit;
    step();
    hitPulse = 1'b0;
    idle();
  endtask

  // Present one pixel, wait the two-cycle latency, then check colour and valid
  task automatic render(input logic [9:0] h, input logic [9:0] v,
                        input logic [11:0] exp, input string tag);
    vid.pixelTick  = 1'b1;
    vid.horizCount = h;
    vid.vertCount  = v;
    step();
    idle();
    step();
    chk(tag, {vid.red, vid.green, vid.blue}, exp);
    chk({tag, "_valid"}, {11'd0, vid.pixelValidOut}, 12'd1);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    blockieee   = 4'd0;
    ddavers     = '0;
    bulletColor = '0;
    bulletXLoc  = '0;
    bulletYLoc  = '0;
    hitPulse    = 1'b0;
    idle();
    step();
    step();
    chk("reset_rgb", {vid.red, vid.green, vid.blue}, 12'h000);
    chk("reset_valid", {11'd0, vid.pixelValidOut}, 12'd0);
    reset = 1'b0;

    // Homeworld and exact latency: (0,0) then (39,0) back to back
    vid.pixelTick = 1'b1; vid.horizCount = 10'd0; vid.vertCount = 10'd0;
    step();
    vid.horizCount = 10'd39;
    chk("lat_not_yet", {11'd0, vid.pixelValidOut}, 12'd0);
    step();
    idle();
    chk("home_0_0", {vid.red, vid.green, vid.blue}, 12'h282);
    chk("home_0_0_valid", {11'd0, vid.pixelValidOut}, 12'd1);
    step();
    chk("home_39_0", {vid.red, vid.green, vid.blue}, 12'h282);
    chk("home_39_0_valid", {11'd0, vid.pixelValidOut}, 12'd1);
    step();
    chk("valid_drops", {11'd0, vid.pixelValidOut}, 12'd0);
    render(10'd40, 10'd0, 12'hFFF, "player_row0");

    // Snapshot isolation
    blockieee = 4'd3;
    frame_start(1'b0);
    blockieee = 4'd5;
    render(10'd50, 10'd130, 12'hFFF, "snap_old_row");
    render(10'd50, 10'd210, 12'h000, "snap_new_row_hidden");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "snap_new_row_seen");

    // Priority: bullet0 over bullet1 over enemy at cell (4,1)
    bulletColor[11:0]  = 12'hF00; bulletXLoc[3:0] = 4'd4; bulletYLoc[3:0] = 4'd1;
    bulletColor[23:12] = 12'h0F0; bulletXLoc[7:4] = 4'd4; bulletYLoc[7:4] = 4'd1;
    ddavers[11:0]      = 12'h00F;
    frame_start(1'b0);
    render(10'd170, 10'd50, 12'hF00, "prio_bullet0");
    bulletColor[11:0] = 12'h000;
    frame_start(1'b0);
    render(10'd170, 10'd50, 12'h0F0, "prio_bullet1");
    bulletColor[23:12] = 12'h000;
    frame_start(1'b0);
    render(10'd170, 10'd50, 12'h00F, "prio_enemy");

    // Enemy field bounds, every enemy i coloured 0x300+i
    for (int i = 0; i < ER*EC; i++) ddavers[12*i +: 12] = 12'h300 + 12'(i);
    frame_start(1'b0);
    render(10'd565, 10'd45,  12'h305, "enemy_r0_c5");
    render(10'd330, 10'd210, 12'h30E, "enemy_r2_c2");
    render(10'd170, 10'd370, 12'h318, "enemy_r4_c0");
    render(10'd605, 10'd45,  12'h000, "enemy_cell15_1");
    render(10'd170, 10'd10,  12'h000, "enemy_cell4_0");
    render(10'd170, 10'd450, 12'h000, "enemy_row5_out");

    // Flash sequence (player at row 5, cell (1,5))
    hitPulse = 1'b1; step(); hitPulse = 1'b0;
    render(10'd50, 10'd210, 12'hF00, "flash_3");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "flash_2");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hF00, "flash_1");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "flash_0");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "flash_stays_0");
    frame_start(1'b1);
    render(10'd50, 10'd210, 12'hF00, "flash_coinc_from0");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "flash_coinc_then2");
    frame_start(1'b1);
    render(10'd50, 10'd210, 12'hF00, "flash_coinc_from2");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hFFF, "flash_after_reload2");
    frame_start(1'b0);
    render(10'd50, 10'd210, 12'hF00, "flash_after_reload1");

    // Range edges, with bullet2 in the last visible cell (15,11)
    bulletColor[35:24] = 12'h5A5; bulletXLoc[11:8] = 4'd15; bulletYLoc[11:8] = 4'd11;
    frame_start(1'b0);
    render(10'd639, 10'd479, 12'h5A5, "edge_639_479");
    render(10'd640, 10'd0,   12'h000, "edge_640_0");
    render(10'd0,   10'd480, 12'h000, "edge_0_480");

    // Reset mid-stream
    vid.pixelTick = 1'b1; vid.horizCount = 10'd10; vid.vertCount = 10'd10;
    step();
    reset = 1'b1;
    step();
    chk("midreset_rgb", {vid.red, vid.green, vid.blue}, 12'h000);
    chk("midreset_valid", {11'd0, vid.pixelValidOut}, 12'd0);
    reset = 1'b0;
    idle();
    step();
    render(10'd40,  10'd0,   12'hFFF, "post_reset_player_row0");
    render(10'd50,  10'd210, 12'h000, "post_reset_row5_blank");
    render(10'd639, 10'd479, 12'h000, "post_reset_no_bullet");
    render(10'd565, 10'd45,  12'h000, "post_reset_enemy_black");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_grid_renderer.md
# tile_grid_renderer

Pipelined, parametrised successor to the combinational colour generator in the color_crasher display path. It sits between the VGA timing counters and the RGB pins. It converts the pixel position into a grid cell and resolves layer priority across the homeworld column, the player (blockieee), N bullets and an R×C DDaver field. Game state is snapshotted once per frame so that mid-frame updates cannot tear the image, and the player flashes after a hit. Outputs are registered, with a fixed 2-cycle latency.

## Interface
- HPIXELS, 640, visible width in pixels
- VPIXELS, 480, visible height in pixels
- BSIZE, 40, cell edge in pixels
- NBULLETS, 3, bullet channels (1..8)
- ENEMY_ROWS, 5, DDaver rows
- ENEMY_COLS, 6, DDaver columns
- FLASH_FRAMES, 8, frames of player flash per hit (1..255)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixelTick  in  1  horizCount/vertCount valid this cycle
- horizCount  in  10  pixel x
- vertCount  in  10  pixel y
- blockieee  in  4  player cell row (column fixed at 1)
- ddavers  in  12*ENEMY_ROWS*ENEMY_COLS  RGB444 per enemy; index i = r*ENEMY_COLS+c at bits [12i+11:12i]
- bulletColor  in  12*NBULLETS  RGB444 per bullet; 0 = inactive
- bulletXLoc  in  4*NBULLETS  bullet cell column
- bulletYLoc  in  4*NBULLETS  bullet cell row
- hitPulse  in  1  one-cycle player-hit strobe
- red, green, blue  out  4 each  registered colour
- pixelValidOut  out  1  pixelTick delayed 2 cycles

## Operation
- Snapshot: a cycle with pixelTick=1 and horizCount==0 and vertCount==0 is a frame start. On a frame start, every game-state input (blockieee, ddavers, bullet*) is latched into shadow registers. Rendering reads only the shadow registers.
- Stage 1 (registered): cellX = horizCount/BSIZE, cellY = vertCount/BSIZE, inRange = (horizCount < HPIXELS) && (vertCount < VPIXELS), plus tick.
- Stage 2 (registered): priority mux on stage-1 values. The first matching rule wins:
  1. !inRange → 0,0,0
  2. cellX==0 → homeworld 2,8,2
  3. cellX==1 && cellY==blockieee → player: 15,0,0 if flashCnt is odd, else 15,15,15
  4. bullet k, in ascending k: cellX==XLoc[k] && cellY==YLoc[k] && color[k]!=0 → color[k]
  5. cellY odd && cellX even && cellX>=4: r=cellY/2, c=cellX/2-2. If r<ENEMY_ROWS && c<ENEMY_COLS → ddavers[r][c], else backdrop
  6. backdrop 0,0,0
- Flash counter (8 bit):
  - hitPulse loads FLASH_FRAMES. This includes while a flash is already active.
  - Otherwise, on each frame start with flashCnt != 0, flashCnt decrements by 1.
  - If hitPulse and a frame start occur in the same cycle, the load wins.
- Arithmetic: cell indices are unsigned with no truncation: cellX ≤ 1023/BSIZE. Comparisons against 4-bit inputs zero-extend the input.

## Timing
- Reset (synchronous): red/green/blue=0, pixelValidOut=0, pipeline tick bits=0, shadow registers=0 (blockieee row 0, all bullets inactive, all enemies black), flashCnt=0.
- The pipeline advances every clk, regardless of pixelTick. The colour for inputs sampled at edge N appears on the outputs after edge N+1, i.e. 2 cycles of latency. pixelValidOut mirrors pixelTick with the same latency.
- The frame-start pixel (0,0) itself renders with the newly latched snapshot.
- Inputs that change between frame starts have no visible effect until the next frame start.
- Reset asserted mid-frame: outputs are 0 on the next cycle. After release, state stays at snapshot zeros until the first frame start.
- Out-of-range pixels (horizCount ≥ HPIXELS or vertCount ≥ VPIXELS) produce 0, independent of all other rules.

## Test plan
- Homeworld and latency: reset, then tick (0,0) followed by (39,0). Colour 2,8,2 appears exactly 2 cycles after each tick, and pixelValidOut is aligned with it. Tick (40,0) with blockieee=0 snapshotted → 15,15,15.
- Snapshot isolation: at frame start set blockieee=3, then change it to 5 mid-frame. Tick (50,130) → 15,15,15; tick (50,210) → backdrop 0. After the next frame start, (50,210) → white.
- Priority: bullet0 and bullet1 both at cell (4,1) with colours 0xF00 and 0x0F0, and ddavers[0][0]=0x00F. Pixel (170,50) → 15,0,0. Clear bullet0 colour → 0,15,0. Clear both → 0,0,15.
- Enemy bounds: ENEMY_COLS=6. Pixel in cell (14,1) → ddavers[0][5]. Cell (15,1) → 0. Cell (4,0) → 0. Cell (4,11) with ENEMY_ROWS=5 → 0, since r=5 is out of range.
- Flash: hitPulse with FLASH_FRAMES=3. Player cell shows red in frames where flashCnt is odd (3,1) and white where it is 2 or 0. A hitPulse coincident with a frame start reloads to 3.
- Range edge and reset: pixel (639,479) renders normally. Pixels (640,0) and (0,480) → 0. Reset asserted mid-stream → next-cycle outputs 0 and pixelValidOut=0.
